// File: rtl/mc_control_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory.
// The FSM side uses the master modport; the datapath side uses slave.
interface mc_control_if;
    logic [5:0]  op_code;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        iord;
    logic        memwrite;
    logic        irwrite;
    logic        regdest;
    logic        memtoreg;
    logic        regwrite;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  aluop;
    logic [1:0]  pcsrc;
    logic        pcen;
    logic [3:0]  state;
    logic        illegal_op;
    logic        mem_err;
    logic [31:0] instr_count;

    modport master (
        input  op_code, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regdest, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, state, illegal_op,
               mem_err, instr_count
    );

    modport slave (
        output op_code, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regdest, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, state, illegal_op,
               mem_err, instr_count
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control unit: Moore-decoded datapath controls,
// memory handshake with a bounded wait, and a retired-instruction counter.
module mc_control_fsm #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    mc_control_if.master bus
);
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Last wait-count value tolerated before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    state_t      state_reg;
    logic [7:0]  wait_reg;
    logic [31:0] count_reg;
    logic        mem_err_reg;

    logic        in_mem_state;
    logic        abandon;
    logic        retire;
    logic        op_known;

    // Decoded controls before reset/timeout strobe suppression.
    logic        mem_req_dec;
    logic        iord_dec;
    logic        memwrite_dec;
    logic        irwrite_dec;
    logic        regdest_dec;
    logic        memtoreg_dec;
    logic        regwrite_dec;
    logic        alusrca_dec;
    logic [1:0]  alusrcb_dec;
    logic [1:0]  aluop_dec;
    logic [1:0]  pcsrc_dec;
    logic        pcen_dec;

    // Classify the current cycle: memory wait, timeout abandon, retirement, opcode validity.
    always_comb begin
        in_mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                       (state_reg == S_MEMWR);
        abandon      = in_mem_state && !bus.mem_ready && (wait_reg == WAIT_LAST);
        case (state_reg)
            S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_JEX: retire = 1'b1;
            S_MEMWR: retire = bus.mem_ready;
            default: retire = 1'b0;
        endcase
        op_known = (bus.op_code == OP_LW)    || (bus.op_code == OP_SW)   ||
                   (bus.op_code == OP_RTYPE) || (bus.op_code == OP_ADDI) ||
                   (bus.op_code == OP_BEQ)   || (bus.op_code == OP_J);
    end

    // State sequencing, wait counter, timeout pulse and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            wait_reg    <= '0;
            count_reg   <= '0;
            mem_err_reg <= 1'b0;
        end else begin
            mem_err_reg <= abandon;

            // The counter only survives while a memory state is held waiting;
            // every other cycle leaves it at zero so each entry starts fresh.
            if (in_mem_state && !bus.mem_ready && !abandon) begin
                wait_reg <= wait_reg + 8'd1;
            end else begin
                wait_reg <= '0;
            end

            if (retire) begin
                count_reg <= count_reg + 32'd1;
            end

            case (state_reg)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state_reg <= S_DECODE;
                    end else begin
                        state_reg <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    case (bus.op_code)
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_RTYPE:     state_reg <= S_RTYPEEX;
                        OP_ADDI:      state_reg <= S_ADDIEX;
                        OP_BEQ:       state_reg <= S_BEQEX;
                        OP_J:         state_reg <= S_JEX;
                        default:      state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (bus.op_code == OP_LW) begin
                        state_reg <= S_MEMRD;
                    end else begin
                        state_reg <= S_MEMWR;
                    end
                end
                S_MEMRD: begin
                    if (bus.mem_ready) begin
                        state_reg <= S_MEMWB;
                    end else if (abandon) begin
                        state_reg <= S_FETCH;
                    end else begin
                        state_reg <= S_MEMRD;
                    end
                end
                S_MEMWR: begin
                    if (bus.mem_ready || abandon) begin
                        state_reg <= S_FETCH;
                    end else begin
                        state_reg <= S_MEMWR;
                    end
                end
                S_RTYPEEX: state_reg <= S_RTYPEWB;
                S_ADDIEX:  state_reg <= S_ADDIWB;
                S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_JEX: state_reg <= S_FETCH;
                default:   state_reg <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the datapath controls from the current state.
    always_comb begin
        mem_req_dec  = 1'b0;
        iord_dec     = 1'b0;
        memwrite_dec = 1'b0;
        irwrite_dec  = 1'b0;
        regdest_dec  = 1'b0;
        memtoreg_dec = 1'b0;
        regwrite_dec = 1'b0;
        alusrca_dec  = 1'b0;
        alusrcb_dec  = 2'b00;
        aluop_dec    = 2'b00;
        pcsrc_dec    = 2'b00;
        pcen_dec     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req_dec = 1'b1;
                alusrcb_dec = 2'b01;
                // The IR and PC only load once the instruction word has arrived.
                irwrite_dec = bus.mem_ready;
                pcen_dec    = bus.mem_ready;
            end
            S_DECODE: begin
                alusrcb_dec = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca_dec = 1'b1;
                alusrcb_dec = 2'b10;
            end
            S_MEMRD: begin
                mem_req_dec = 1'b1;
                iord_dec    = 1'b1;
            end
            S_MEMWR: begin
                mem_req_dec  = 1'b1;
                iord_dec     = 1'b1;
                memwrite_dec = 1'b1;
            end
            S_MEMWB: begin
                memtoreg_dec = 1'b1;
                regwrite_dec = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca_dec = 1'b1;
                aluop_dec   = 2'b10;
            end
            S_RTYPEWB: begin
                regdest_dec  = 1'b1;
                regwrite_dec = 1'b1;
            end
            S_ADDIWB: begin
                regwrite_dec = 1'b1;
            end
            S_BEQEX: begin
                alusrca_dec = 1'b1;
                aluop_dec   = 2'b01;
                pcsrc_dec   = 2'b01;
                pcen_dec    = bus.zero;
            end
            S_JEX: begin
                pcsrc_dec = 2'b10;
                pcen_dec  = 1'b1;
            end
            default: begin
                mem_req_dec = 1'b0;
            end
        endcase
    end

    // Strobes are killed while reset is held and in the cycle an access is abandoned,
    // so neither a half-finished write nor a stray register load can escape.
    assign bus.mem_req     = mem_req_dec  && !rst && !abandon;
    assign bus.memwrite    = memwrite_dec && !rst && !abandon;
    assign bus.irwrite     = irwrite_dec  && !rst && !abandon;
    assign bus.pcen        = pcen_dec     && !rst && !abandon;
    assign bus.regwrite    = regwrite_dec && !rst && !abandon;
    assign bus.iord        = iord_dec;
    assign bus.regdest     = regdest_dec;
    assign bus.memtoreg    = memtoreg_dec;
    assign bus.alusrca     = alusrca_dec;
    assign bus.alusrcb     = alusrcb_dec;
    assign bus.aluop       = aluop_dec;
    assign bus.pcsrc       = pcsrc_dec;
    assign bus.state       = state_reg;
    assign bus.illegal_op  = (state_reg == S_DECODE) && !op_known;
    assign bus.mem_err     = mem_err_reg;
    assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench: an instruction-level model expands each directed
// instruction into its expected cycle trace, and the run compares the DUT
// against that trace every cycle.
module tb_mc_control_fsm;
    localparam int TO = 4;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
    localparam int RTYPEEX = 6, RTYPEWB = 7, BEQEX = 8, ADDIEX = 9, ADDIWB = 10, JEX = 11;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdest;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal_op;
        logic       mem_err;
    } ctl_t;

    typedef struct {
        bit          chk;
        bit          rst;
        logic [5:0]  op;
        bit          zero;
        bit          rdy;
        ctl_t        ctl;
        logic [31:0] cnt;
        string       tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_control_if bus ();

    mc_control_fsm #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t        q[$];
    logic [31:0] m_count = '0;
    bit          err_pending = 1'b0;
    logic [5:0]  cur_op = '0;
    bit          cur_zero = 1'b0;
    string       cur_tag = "";
    int          n_cmp = 0;
    int          n_bad = 0;

    // Control values the spec table lists for one state.
    function automatic ctl_t table_out(int st, bit rdy, logic [5:0] op, bit z);
        ctl_t c;
        c = '0;
        c.state = 4'(st);
        case (st)
            FETCH:   begin c.mem_req = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcen = rdy; end
            DECODE:  begin c.alusrcb = 2'b11;
                           c.illegal_op = !(op inside {LW, SW, RT, ADDI, BEQ, JMP}); end
            MEMADR, ADDIEX: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            MEMRD:   begin c.mem_req = 1; c.iord = 1; end
            MEMWR:   begin c.mem_req = 1; c.iord = 1; c.memwrite = 1; end
            MEMWB:   begin c.memtoreg = 1; c.regwrite = 1; end
            RTYPEEX: begin c.alusrca = 1; c.aluop = 2'b10; end
            RTYPEWB: begin c.regdest = 1; c.regwrite = 1; end
            ADDIWB:  begin c.regwrite = 1; end
            BEQEX:   begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = z; end
            JEX:     begin c.pcsrc = 2'b10; c.pcen = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Append one expected cycle; r = reset held this cycle, ab = access abandoned.
    task automatic emit(input int st, input bit rdy, input bit r, input bit ab);
        vec_t v;
        v.chk  = 1'b1;
        v.rst  = r;
        v.op   = cur_op;
        v.zero = cur_zero;
        v.rdy  = rdy;
        v.ctl  = table_out(st, rdy, cur_op, cur_zero);
        if (r || ab) begin
            v.ctl.mem_req  = 1'b0;
            v.ctl.memwrite = 1'b0;
            v.ctl.irwrite  = 1'b0;
            v.ctl.pcen     = 1'b0;
            v.ctl.regwrite = 1'b0;
        end
        v.ctl.mem_err = err_pending;
        v.cnt = m_count;
        v.tag = cur_tag;
        cur_tag = "";
        q.push_back(v);
        err_pending = ab && !r;
        if (r) m_count = '0;
    endtask

    // A memory state answered after lat idle cycles, or abandoned at the timeout.
    task automatic mem_wait(input int st, input int lat, output bit ok);
        ok = 1'b1;
        for (int k = 0; k < lat; k++) begin
            if (k == TO - 1) begin
                emit(st, 1'b0, 1'b0, 1'b1);
                ok = 1'b0;
                return;
            end
            emit(st, 1'b0, 1'b0, 1'b0);
        end
        emit(st, 1'b1, 1'b0, 1'b0);
    endtask

    // One instruction: fetch latency flat, data latency mlat, nz = mem_ready noise elsewhere.
    task automatic instr(input logic [5:0] op, input bit z, input int flat, input int mlat,
                         input bit nz, input string tag);
        bit ok;
        cur_op = op;
        cur_zero = z;
        cur_tag = tag;
        mem_wait(FETCH, flat, ok);
        if (!ok) return;
        emit(DECODE, nz, 1'b0, 1'b0);
        case (op)
            LW: begin
                emit(MEMADR, nz, 1'b0, 1'b0);
                mem_wait(MEMRD, mlat, ok);
                if (ok) begin
                    emit(MEMWB, nz, 1'b0, 1'b0);
                    m_count = m_count + 1;
                end
            end
            SW: begin
                emit(MEMADR, nz, 1'b0, 1'b0);
                mem_wait(MEMWR, mlat, ok);
                if (ok) m_count = m_count + 1;
            end
            RT:   begin emit(RTYPEEX, nz, 0, 0); emit(RTYPEWB, nz, 0, 0); m_count = m_count + 1; end
            ADDI: begin emit(ADDIEX, nz, 0, 0);  emit(ADDIWB, nz, 0, 0);  m_count = m_count + 1; end
            BEQ:  begin emit(BEQEX, nz, 0, 0);   m_count = m_count + 1; end
            JMP:  begin emit(JEX, nz, 0, 0);     m_count = m_count + 1; end
            default: ;
        endcase
    endtask

    function automatic int count_field(int s, int e, int f);
        int n = 0;
        for (int i = s; i < e; i++) begin
            case (f)
                0: n += int'(q[i].ctl.regwrite);
                1: n += int'(q[i].ctl.memwrite);
                2: n += int'(q[i].ctl.irwrite | q[i].ctl.pcen);
                3: n += int'(q[i].ctl.state == 4'(FETCH));
                default: n += int'(q[i].ctl.memtoreg & q[i].ctl.regwrite);
            endcase
        end
        return n;
    endfunction

    // Literal check on the model's own trace.
    task automatic pin(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL pin %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    initial begin
        vec_t        v;
        ctl_t        act;
        int          s;
        int          cyc;
        bit          ok;
        logic [31:0] c0;
        logic [19:0] seq;

        bus.op_code = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset: first cycle unchecked (state unknown), second checks reset state.
        v.chk = 1'b0; v.rst = 1'b1; v.op = '0; v.zero = 1'b0; v.rdy = 1'b0;
        v.ctl = '0; v.cnt = '0; v.tag = "reset";
        q.push_back(v);
        emit(FETCH, 1'b0, 1'b1, 1'b0);

        s = q.size();
        instr(LW, 0, 0, 0, 0, "lw, memory ready at once");
        pin("lw length", q.size() - s, 5);
        seq = {q[s].ctl.state, q[s+1].ctl.state, q[s+2].ctl.state, q[s+3].ctl.state, q[s+4].ctl.state};
        pin("lw state walk", int'(seq), 'h01234);
        pin("lw regwrite with memtoreg", count_field(s, q.size(), 4), 1);
        pin("lw count", int'(m_count), 1);

        c0 = m_count; s = q.size();
        instr(SW, 0, 1, 3, 0, "sw, write ready after 3 waits");
        pin("sw memwrite cycles", count_field(s, q.size(), 1), 4);
        pin("sw regwrite cycles", count_field(s, q.size(), 0), 0);
        pin("sw count step", int'(m_count - c0), 1);

        instr(BEQ, 1, 0, 0, 1, "beq zero=1");
        pin("beq taken pcen", int'(q[q.size()-1].ctl.pcen), 1);
        pin("beq taken pcsrc", int'(q[q.size()-1].ctl.pcsrc), 1);
        instr(BEQ, 0, 2, 0, 1, "beq zero=0");
        pin("beq not-taken pcen", int'(q[q.size()-1].ctl.pcen), 0);
        pin("beq not-taken pcsrc", int'(q[q.size()-1].ctl.pcsrc), 1);

        instr(RT, 0, 0, 0, 1, "rtype");
        instr(ADDI, 0, 1, 0, 1, "addi");
        instr(JMP, 0, 0, 0, 1, "j");

        c0 = m_count;
        instr(BAD, 0, 0, 0, 1, "illegal opcode 111111");
        pin("illegal flag", int'(q[q.size()-1].ctl.illegal_op), 1);
        pin("illegal count step", int'(m_count - c0), 0);

        s = q.size();
        instr(ADDI, 0, 10, 0, 0, "fetch timeout");
        pin("timeout fetch cycles", count_field(s, q.size(), 3), 4);
        pin("timeout irwrite/pcen", count_field(s, q.size(), 2), 0);
        s = q.size();
        instr(ADDI, 0, 0, 0, 0, "addi after timeout");
        pin("mem_err pulse", int'(q[s].ctl.mem_err), 1);
        pin("mem_err one cycle", int'(q[s+1].ctl.mem_err), 0);

        instr(LW, 0, 0, 3, 0, "lw, data on last allowed cycle");
        instr(LW, 0, 0, 4, 1, "lw, read timeout");
        instr(SW, 0, 0, 10, 0, "sw, write timeout");
        cur_tag = "reset right after timeout";
        emit(FETCH, 1'b0, 1'b1, 1'b0);

        instr(LW, 0, 2, 1, 1, "lw");
        instr(ADDI, 0, 0, 0, 0, "addi");
        cur_op = RT; cur_zero = 0; cur_tag = "reset during rtypeex";
        mem_wait(FETCH, 0, ok);
        emit(DECODE, 1'b0, 1'b0, 1'b0);
        emit(RTYPEEX, 1'b0, 1'b1, 1'b0);
        pin("count after reset", int'(m_count), 0);

        cur_op = LW; cur_tag = "reset mid-wait in memrd";
        mem_wait(FETCH, 1, ok);
        emit(DECODE, 1'b0, 1'b0, 1'b0);
        emit(MEMADR, 1'b0, 1'b0, 1'b0);
        emit(MEMRD, 1'b0, 1'b0, 1'b0);
        emit(MEMRD, 1'b0, 1'b1, 1'b0);

        instr(SW, 0, 0, 2, 1, "sw");
        instr(RT, 0, 1, 0, 0, "rtype");
        instr(JMP, 0, 0, 0, 0, "j");

        // Drive each vector just after a rising edge, compare on the falling edge.
        cyc = 0;
        while (q.size() > 0) begin
            v = q.pop_front();
            @(posedge clk);
            #1;
            rst = v.rst;
            bus.op_code = v.op;
            bus.zero = v.zero;
            bus.mem_ready = v.rdy;
            if (v.tag != "") $display("[cycle %0d] txn: %s", cyc, v.tag);
            @(negedge clk);
            if (v.chk) begin
                act = {bus.state, bus.mem_req, bus.iord, bus.memwrite, bus.irwrite,
                       bus.regdest, bus.memtoreg, bus.regwrite, bus.alusrca,
                       bus.alusrcb, bus.aluop, bus.pcsrc, bus.pcen, bus.illegal_op,
                       bus.mem_err};
                n_cmp++;
                if (act !== v.ctl) begin
                    n_bad++;
                    $display("FAIL controls cycle %0d: got %06h (state %0d), required %06h (state %0d)",
                             cyc, act, act.state, v.ctl, v.ctl.state);
                end
                n_cmp++;
                if (bus.instr_count !== v.cnt) begin
                    n_bad++;
                    $display("FAIL instr_count cycle %0d: got %0d, required %0d",
                             cyc, bus.instr_count, v.cnt);
                end
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum number of cycles to wait for mem_ready in any memory state (legal range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 op_code  input  6  instruction opcode field from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completion for the current access, sampled on the rising edge.
REQ-007 mem_req  output  1  memory access request.
REQ-008 iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 memwrite  output  1  memory write enable.
REQ-010 irwrite  output  1  instruction register load enable.
REQ-011 regdest  output  1  register write address select: 1 = rd, 0 = rt.
REQ-012 memtoreg  output  1  register write data select: 1 = memory data, 0 = ALU result.
REQ-013 regwrite  output  1  register file write enable.
REQ-014 alusrca  output  1  ALU A source: 0 = PC, 1 = register A.
REQ-015 alusrcb  output  2  ALU B source: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-016 aluop  output  2  ALU decoder op: 00 = add, 01 = subtract, 10 = use funct field.
REQ-017 pcsrc  output  2  PC source: 00 = ALU, 01 = ALU result register, 10 = jump target.
REQ-018 pcen  output  1  PC load enable.
REQ-019 state  output  4  current state encoding, for debug.
REQ-020 illegal_op  output  1  unknown opcode detected.
REQ-021 mem_err  output  1  one-cycle memory timeout pulse.
REQ-022 instr_count  output  32  retired instruction counter.

Function
REQ-023 State encoding shall be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; codes 12-15 shall go to FETCH on the next cycle.
REQ-024 Outputs shall be Moore-decoded from state, with the handshake qualification of REQ-026; any output not listed for a state shall be 0.
REQ-025 Per-state outputs shall be:
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
- DECODE: alusrcb=11, aluop=00.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: mem_req=1, iord=1.
- MEMWR: mem_req=1, iord=1, memwrite=1.
- MEMWB: memtoreg=1, regwrite=1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
- RTYPEWB: regdest=1, regwrite=1.
- ADDIWB: regwrite=1.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero.
- JEX: pcsrc=10, pcen=1.
REQ-026 In FETCH, irwrite and pcen shall be 1 only in a cycle where mem_ready=1.
REQ-027 FETCH, MEMRD and MEMWR shall hold while mem_ready=0 and shall advance on mem_ready=1: FETCH->DECODE, MEMRD->MEMWB, MEMWR->FETCH.
REQ-028 DECODE shall branch on op_code as follows: 100011 or 101011 -> MEMADR; 000000 -> RTYPEEX; 001000 -> ADDIEX; 000100 -> BEQEX; 000010 -> JEX; any other value -> FETCH with illegal_op=1 during that DECODE cycle.
REQ-029 MEMADR shall go to MEMRD if op_code=100011, otherwise to MEMWR.
REQ-030 Unconditional transitions shall be: MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH; RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
REQ-031 A wait counter shall clear on entry to any memory state and increment each cycle that mem_ready=0.
REQ-032 When the wait counter reaches TIMEOUT-1 with mem_ready=0, the FSM shall go to FETCH, pulse mem_err for the next cycle, and suppress every strobe in the abandoning cycle.
REQ-033 instr_count shall increment by 1, wrapping modulo 2^32, on each transition into FETCH from MEMWB, RTYPEWB, ADDIWB, BEQEX or JEX, or from MEMWR on mem_ready.
REQ-034 Illegal-opcode aborts, timeouts and reset shall not increment instr_count.
REQ-035 A mem_ready pulse arriving outside FETCH, MEMRD or MEMWR shall be ignored.

Reset
REQ-036 While rst=1, regwrite, memwrite, irwrite, pcen and mem_req shall be forced to 0 regardless of state.
REQ-037 On a rising edge with rst=1: state=FETCH, wait counter=0, instr_count=0, mem_err=0.
REQ-038 Reset asserted in any state, including mid-wait, shall abandon the instruction and produce no strobe in the following cycle other than FETCH outputs.

Verification
REQ-039 lw (100011) with mem_ready=1 immediately -> states 0,1,2,3,4,0 over 5 cycles; one regwrite with memtoreg=1; instr_count 0->1.
REQ-040 sw (101011) with mem_ready delayed 3 cycles in MEMWR -> memwrite held 4 cycles; regwrite never asserted; instr_count increments once.
REQ-041 beq (000100) run with zero=1, then with zero=0 -> pcen=1 in BEQEX for the first and pcen=0 for the second; pcsrc=01 in both.
REQ-042 op_code=111111 -> illegal_op=1 in the DECODE cycle; next state FETCH; instr_count unchanged.
REQ-043 TIMEOUT=4 with mem_ready held 0 in FETCH -> FETCH for 4 cycles, mem_err pulses once, irwrite and pcen stay 0 throughout.
REQ-044 rst asserted during RTYPEEX -> next state 0, regwrite never asserted, instr_count=0.
